ring_node_rx: RTL

Receive side of one ring stop, the counterpart to the injection port on which a core places `packetSendIn`/`packetCoreIn`. It accepts packets arriving on the upstream ring link and sorts them by destination:
- Packets with `dest == NODE_ID` are queued in a local eject FIFO and handed to the core over a valid/ready handshake.
- All other in-range packets are forwarded downstream through a one-entry pipeline register.
- Packets with an out-of-range `dest` are discarded.

Backpressure from either path stalls the upstream link.

---
 rtl/ring_node_rx_pkg.sv | 47 ++++
 rtl/ring_eject_fifo.sv | 73 +++++++
 rtl/ring_node_rx.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ring_node_rx_pkg.sv
// ============================================================================
// Module   : ring_node_rx_pkg
// Purpose  : Shared ring-network types: packet layout, node count and the
//            destination class used by both the receive and injection sides.
// Contents : NUM_NODES, pkt_t, dest_class_e, classify_dest()
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef NUMNODES
`define NUMNODES 4
`endif

package ring_node_rx_pkg;

  localparam int NUM_NODES = `NUMNODES;
  localparam int DEST_W    = 4;
  localparam int SRC_W     = 4;
  localparam int DATA_W    = 8;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] data;
  } pkt_t;

  typedef enum logic [1:0] {
    LOCAL   = 2'd0,
    THROUGH = 2'd1,
    BAD     = 2'd2
  } dest_class_e;

  // LOCAL is tested first; node_id is always a legal node so the order of
  // the BAD and LOCAL tests cannot conflict.
  function automatic dest_class_e classify_dest(input logic [DEST_W-1:0] dest,
                                                input int node_id);
    if (int'(dest) == node_id)
      return LOCAL;
    else if (int'(dest) >= NUM_NODES)
      return BAD;
    else
      return THROUGH;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ring_eject_fifo.sv
// ============================================================================
// Module   : ring_eject_fifo
// Purpose  : Circular-buffer FIFO holding packets destined for the local core.
// Ports    : clk, rst_l            - clock, async active-low reset
//            push / push_pkt       - write packet at tail (ignored when full)
//            pop                   - remove head entry (ignored when empty)
//            head                  - head entry, undefined while empty
//            full / empty / count  - decoded from the occupancy register
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_eject_fifo
  import ring_node_rx_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             push,
  input  pkt_t             push_pkt,
  input  logic             pop,
  output pkt_t             head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  pkt_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  assign w_push = push && !full;
  assign w_pop  = pop  && !empty;

  // Storage needs no reset: the head is only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= push_pkt;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ring_node_rx.sv
// ============================================================================
// Module   : ring_node_rx
// Purpose  : Receive side of a ring stop. Classifies upstream packets, ejects
//            local ones to the core through a FIFO, forwards the rest through
//            a one-entry register and discards out-of-range destinations.
// Ports    : clk, rst_l                    - clock, async active-low reset
//            in_valid/in_pkt/in_ready      - upstream ring link
//            fwd_valid/fwd_pkt/fwd_ready   - downstream ring link
//            ej_valid/ej_pkt/ej_ready      - eject port to the core
//            full, ej_count                - eject FIFO status
//            drop_pulse                    - one cycle per discarded packet
//            rx_total                      - saturating ejected-packet count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_node_rx
  import ring_node_rx_pkg::*;
#(
  parameter  int NODE_ID = 0,
  parameter  int DEPTH   = 4,
  localparam int CNT_W   = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             in_valid,
  input  pkt_t             in_pkt,
  output logic             in_ready,
  output logic             fwd_valid,
  output pkt_t             fwd_pkt,
  input  logic             fwd_ready,
  output logic             ej_valid,
  output pkt_t             ej_pkt,
  input  logic             ej_ready,
  output logic             full,
  output logic [CNT_W-1:0] ej_count,
  output logic             drop_pulse,
  output logic [15:0]      rx_total
);

  dest_class_e w_class;
  logic        w_acc;
  logic        w_local_acc;
  logic        w_thru_acc;
  logic        w_bad_acc;
  logic        w_pop;
  logic        w_empty;
  logic        w_full;

  logic        r_fwd_valid;
  pkt_t        r_fwd_pkt;
  logic        r_drop;
  logic [15:0] r_rx_total;

  assign w_class = classify_dest(in_pkt.dest, NODE_ID);

  // A full FIFO refuses a local packet even when the core pops this cycle,
  // keeping in_ready off the ej_ready path.
  always_comb begin
    in_ready = 1'b1;
    case (w_class)
      LOCAL:   in_ready = !w_full;
      THROUGH: in_ready = !r_fwd_valid || fwd_ready;
      default: in_ready = 1'b1;
    endcase
  end

  assign w_acc       = in_valid && in_ready;
  assign w_local_acc = w_acc && (w_class == LOCAL);
  assign w_thru_acc  = w_acc && (w_class == THROUGH);
  assign w_bad_acc   = w_acc && (w_class == BAD);
  assign w_pop       = !w_empty && ej_ready;

  ring_eject_fifo #(
    .DEPTH    (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_l    (rst_l),
    .push     (w_local_acc),
    .push_pkt (in_pkt),
    .pop      (w_pop),
    .head     (ej_pkt),
    .full     (w_full),
    .empty    (w_empty),
    .count    (ej_count)
  );

  // Forward stage: a load always wins over a drain, so drain+load in one
  // cycle replaces the contents with fwd_valid staying high.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_fwd_valid <= 1'b0;
      r_fwd_pkt   <= '0;
    end else if (w_thru_acc) begin
      r_fwd_valid <= 1'b1;
      r_fwd_pkt   <= in_pkt;
    end else if (fwd_ready) begin
      r_fwd_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_drop     <= 1'b0;
      r_rx_total <= '0;
    end else begin
      r_drop <= w_bad_acc;
      if (w_pop && (r_rx_total != 16'hFFFF))
        r_rx_total <= r_rx_total + 16'd1;
    end
  end

  assign fwd_valid  = r_fwd_valid;
  assign fwd_pkt    = r_fwd_pkt;
  assign ej_valid   = !w_empty;
  assign full       = w_full;
  assign drop_pulse = r_drop;
  assign rx_total   = r_rx_total;

endmodule

`default_nettype wire
